// File: rtl/ks_pkg.sv
// Shared types for the multiword add sequencer: FSM state and the default-width output record.
package ks_pkg;

  localparam int KS_WIDTH     = 16;
  localparam int KS_MAX_WORDS = 4;
  localparam int KS_IDX_W     = $clog2(KS_MAX_WORDS);

  typedef enum logic {FIRST, MID} seq_state_t;

  // Output record at the package default width; the top declares the same shape at its own WIDTH.
  typedef struct packed {
    logic [KS_WIDTH-1:0] sum;
    logic [KS_IDX_W-1:0] idx;
    logic                last;
    logic                cout;
    logic                ovf;
    logic                err;
  } out_rec_t;

endpackage

// File: rtl/kogge_stone_adder.sv
// Combinational parallel-prefix (Kogge-Stone) adder with carry-in and carry-out.
module kogge_stone_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carries;

  assign prop = a ^ b;

  // Prefix tree: after log2(WIDTH) levels, carries[i] is the carry out of bit i.
  always_comb begin
    logic [WIDTH-1:0] g, p, g_n, p_n;
    // cin folds into bit 0 generate so the tree needs no extra column
    g = (a & b) | {{(WIDTH-1){1'b0}}, prop[0] & cin};
    p = prop;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < WIDTH; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    carries = g;
  end

  assign sum  = prop ^ {carries[WIDTH-2:0], cin};
  assign cout = carries[WIDTH-1];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Streaming multi-precision add/sub: one word pair per beat, LS word first, registered carry chain.
module multiword_add_sequencer
  import ks_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 4,
  parameter int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             cout;
    logic             ovf;
    logic             err;
  } rec_t;

  seq_state_t       state_q;
  logic             carry_q;
  logic             sub_q;
  logic [IDX_W-1:0] idx_q;
  rec_t             out_q;
  logic             out_valid_q;

  logic             accept;
  logic             first;
  logic             sub_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             at_max;
  logic             eff_last;
  rec_t             rec_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand conditioning: packet-level controls come from the beat itself only on the first word.
  always_comb begin
    first   = (state_q == FIRST);
    sub_eff = first ? in_sub : sub_q;
    cin_eff = first ? (in_sub | in_cin) : carry_q;
    b_eff   = sub_eff ? ~in_b : in_b;
  end

  kogge_stone_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (in_a),
    .b   (b_eff),
    .cin (cin_eff),
    .sum (sum),
    .cout(cout)
  );

  // Result record for the beat currently offered; flags are only reported on the final word.
  always_comb begin
    at_max      = (idx_q == IDX_W'(MAX_WORDS - 1));
    eff_last    = in_last || at_max;
    rec_d       = '0;
    rec_d.sum   = sum;
    rec_d.idx   = idx_q;
    rec_d.last  = eff_last;
    rec_d.cout  = eff_last & cout;
    rec_d.ovf   = eff_last & (in_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1] ^ cout);
    rec_d.err   = at_max && !in_last;
  end

  // Packet sequencing: carry, index and subtract mode advance on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FIRST;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      if (first) sub_q <= in_sub;
      if (eff_last) begin
        state_q <= FIRST;
        carry_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        state_q <= MID;
        carry_q <= cout;
        idx_q   <= idx_q + IDX_W'(1);
      end
    end
  end

  // Output register: load on accept, drop valid on a take with no new beat, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= rec_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_q.sum;
  assign out_idx   = out_q.idx;
  assign out_last  = out_q.last;
  assign out_cout  = out_q.cout;
  assign out_ovf   = out_q.ovf;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench: driver pushes expected words from a big-integer model, monitor pops on each take.
module tb_multiword_add_sequencer;

  localparam int W = 16;
  localparam int MW = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [1:0]   idx;
    logic         last;
    logic         cout;
    logic         ovf;
    logic         err;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_last, out_cout, out_ovf, out_err;
  logic [W-1:0] out_sum;
  logic [1:0]   out_idx;

  multiword_add_sequencer #(
    .WIDTH    (W),
    .MAX_WORDS(MW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  bit   rand_ready = 0;
  rec_t exp_q[$];

  // Reference model: the open packet so far, kept as whole words.
  logic [W-1:0] pa[MW];
  logic [W-1:0] pb[MW];
  int           m_n = 0;
  logic         m_sub, m_cin;

  rec_t cur;
  assign cur = '{sum: out_sum, idx: out_idx, last: out_last, cout: out_cout, ovf: out_ovf,
                 err: out_err};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word i of the result is the i-th slice of (A + B' + cin) over the words seen so far.
  task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                            input logic cin, input logic sub);
    logic [64:0] av, bv, res;
    int          nb;
    logic        eff_last, sa, sb, sr;
    rec_t        e;
    if (m_n == 0) begin
      m_sub = sub;
      m_cin = cin;
    end
    pa[m_n] = a;
    pb[m_n] = b;
    av = '0;
    bv = '0;
    for (int j = 0; j <= m_n; j++) begin
      av[j*W +: W] = pa[j];
      bv[j*W +: W] = m_sub ? ~pb[j] : pb[j];
    end
    res = av + bv + 65'(m_sub ? 1'b1 : m_cin);
    nb = (m_n + 1) * W;
    sa = av[nb-1];
    sb = bv[nb-1];
    sr = res[nb-1];
    eff_last = last || (m_n == MW - 1);
    e.sum  = res[m_n*W +: W];
    e.idx  = 2'(m_n);
    e.last = eff_last;
    e.cout = eff_last ? res[nb] : 1'b0;
    e.ovf  = eff_last ? ((sa == sb) && (sr != sa)) : 1'b0;
    e.err  = (m_n == MW - 1) && !last;
    exp_q.push_back(e);
    m_n = eff_last ? 0 : m_n + 1;
  endtask

  task automatic set_ready();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one beat until accepted; waits reports cycles spent stalled.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                      input logic cin, input logic sub, output int waits);
    in_a = a; in_b = b; in_last = last; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_push(a, b, last, cin, sub);
        @(posedge clk); #1;
        set_ready();
        break;
      end
      @(posedge clk); #1;
      set_ready();
      waits++;
      if (waits > 200) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      set_ready();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compare each taken word against the scoreboard and check stability under stall.
  bit   hold_prev = 0;
  rec_t prev_rec;
  always @(negedge clk) begin
    rec_t e;
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_stable", 64'(cur), 64'(prev_rec));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(cur), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 64'(cur), 64'(e));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_rec  = cur;
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_outputs", {57'd0, out_valid, out_idx, out_last, out_cout, out_ovf, out_err},
          64'd0);
    check("reset_sum", 64'(out_sum), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Add with carry across words, subtract with borrow, single-beat overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, w);
    send(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, w);
    send(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, w);
    send(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, w);
    send(16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, w);
    idle(2);

    // Backpressure: stall three cycles, then full throughput
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, w);
    in_a = 16'hF000; in_b = 16'h1000; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'hF000, 16'h1000, 1'b1, 1'b0, 1'b0, w);
    check("bp_resume_waits", 64'(w), 64'd0);
    for (int k = 0; k < 4; k++) begin
      send(pick(), pick(), k == 3, 1'b1, 1'b0, w);
      check("throughput_waits", 64'(w), 64'd0);
    end

    // Forced termination: fifth beat opens a new packet with fresh cin/sub
    for (int k = 0; k < 5; k++) send(pick(), pick(), 1'b0, k == 4, k == 4, w);
    send(pick(), pick(), 1'b1, 1'b0, 1'b0, w);
    idle(2);

    // Reset mid-packet: first word of a three-word packet is discarded
    send(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {57'd0, out_valid, out_idx, out_last, out_cout, out_ovf, out_err},
          64'd0);
    check("midrst_sum", 64'(out_sum), 64'd0);
    exp_q.delete();
    m_n = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, w);
    idle(2);

    // Randomized traffic with random consumer stalls
    rand_ready = 1;
    for (int k = 0; k < 250; k++) begin
      send(pick(), pick(), $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), w);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    // Drain
    rand_ready = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Streaming multi-precision adder/subtractor. It accepts operands one WIDTH-bit word pair per beat, least-significant word first, and chains the carry between beats through a registered carry. Each word is summed by a `kogge_stone_adder` instance. The block sits directly upstream of result consumers and wraps the combinational adder with a valid/ready handshake, one output register and packet framing.

## Interface
- `WIDTH`, 16: word width; passed to the adder instance.
- `MAX_WORDS`, 4: maximum beats per packet; must be ≥ 2.
- `IDX_W`, `$clog2(MAX_WORDS)`: derived; width of the word index.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: a beat is offered.
- `in_ready` output 1: the block can take a beat.
- `in_a` input WIDTH: operand A word.
- `in_b` input WIDTH: operand B word.
- `in_last` input 1: final word of the packet.
- `in_cin` input 1: packet carry-in; sampled on the first beat only.
- `in_sub` input 1: 1 means A−B; sampled on the first beat only.
- `out_valid` output 1: the result word is valid.
- `out_ready` input 1: the consumer takes the result.
- `out_sum` output WIDTH: result word.
- `out_idx` output IDX_W: word index within the packet, starting at 0.
- `out_last` output 1: final result word.
- `out_cout` output 1: final carry-out; meaningful only with `out_last`, otherwise 0.
- `out_ovf` output 1: signed overflow of the full-width result; valid with `out_last`, otherwise 0.
- `out_err` output 1: the packet was force-terminated at MAX_WORDS; valid with `out_last`.

## Operation
- Accept: a beat is accepted when `in_valid && in_ready`.
- Ready rule: `in_ready = !out_valid || out_ready`. This is combinational and allows full throughput of one beat per cycle.
- FSM states:
  - FIRST (reset state): the next accepted beat starts a packet.
    - Latch `sub_q = in_sub`.
    - Adder carry-in is `in_sub ? 1 : in_cin`.
    - Set `idx = 0`.
  - MID: adder carry-in is `carry_q`; B is inverted when `sub_q` is 1.
- Per accepted beat:
  - `b_eff = sub ? ~in_b : in_b`.
  - Form `{cout, sum}` from the adder.
  - Load the output register with sum, idx, last flag and flags.
  - Update `carry_q <= cout`.
- Transitions:
  - FIRST goes to MID on accept when the beat is not effectively last.
  - Any state goes to FIRST on accept of an effectively-last beat; `carry_q` and `idx` then clear.
- Effective last is `in_last || idx == MAX_WORDS-1`.
  - `out_err = (idx == MAX_WORDS-1) && !in_last`.
  - The beat after a forced termination starts a new packet.
- Subtract convention: `out_cout = 1` means no borrow.
- Overflow: `out_ovf = c_msb ^ cout`, where `c_msb = in_a[W-1] ^ b_eff[W-1] ^ sum[W-1]`.
- Output register:
  - Holds its contents while `out_valid && !out_ready`; all output fields stay stable.
  - Clears `out_valid` on a take when no new accept occurs in the same cycle.
- Simultaneous take and accept: the register reloads and `out_valid` stays 1.
- Reset (async, any time, including mid-packet):
  - All outputs go to 0: `out_valid`, `out_sum`, `out_idx`, `out_last`, `out_cout`, `out_ovf`, `out_err`.
  - State goes to FIRST; `carry_q` and `sub_q` go to 0.
  - The in-flight packet is discarded without a result.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- A packet of N words produces exactly N result beats in order. The final beat carries `out_last = 1`.
- `in_ready` is 1 out of reset. It depends combinationally on `out_ready`; there is no combinational path from `in_valid`.
- No bubble is required between packets.

## Structure
- Package `ks_pkg`:
  - `typedef enum logic {FIRST, MID} seq_state_t`.
  - Output record `typedef struct packed` holding sum, idx, last, cout, ovf and err; it is parameterised via the package default WIDTH=16.
- Sub-module: one `kogge_stone_adder #(.WIDTH(WIDTH))` instance; no other sub-modules.
- Registers: FSM state, `carry_q`, `sub_q`, `idx`, and the output record.

## Test plan (WIDTH=16, MAX_WORDS=4)
- Add with carry across words: A=0x0001_FFFF, B=0x0000_0001, cin=0, 2 beats → 0xFFFF+0x0001 gives `out_sum` 0x0000 at idx 0; 0x0001+0x0000+1 gives 0x0002 at idx 1, last=1, cout=0, ovf=0.
- Subtract with borrow: sub=1, A=0x0000_0000, B=0x0000_0001 → 0xFFFF, then 0xFFFF with last=1, cout=0 (borrow), ovf=0.
- Single-beat signed overflow: A=0x7FFF, B=0x0001, last=1 → `out_sum` 0x8000, ovf=1, cout=0, idx=0.
- Backpressure: `out_ready` low for 3 cycles while `out_valid` is high → `in_ready` is 0, output fields stay stable, no beat is lost or duplicated; resuming yields 1 beat/cycle.
- Forced termination: 5 beats with `in_last=0` → beat 4 has idx=3, last=1, err=1; beat 5 has idx=0 and uses the newly sampled `in_cin`/`in_sub`.
- Reset mid-packet: assert `rst` after the first word of a 3-word packet → `out_valid` goes to 0 immediately and all outputs are 0; the next beat is treated as FIRST with carry-in = `in_cin`.
